// File: rtl/sseg_display_arbiter_if.sv
// Request/data/display bundle between the digit sources and the seven-segment arbiter.
interface sseg_display_arbiter_if #(
    parameter int unsigned NUM_SRC = 4
);
    logic [NUM_SRC-1:0]    req;
    logic [NUM_SRC-1:0]    urgent;
    logic                  freeze;
    logic [NUM_SRC*32-1:0] src_digits;
    logic [NUM_SRC*8-1:0]  src_blank;
    logic [31:0]           bcd_out;
    logic [7:0]            blank_out;
    logic [NUM_SRC-1:0]    grant;
    logic                  active;
    logic                  switch_pulse;

    modport master (
        output req, urgent, freeze, src_digits, src_blank,
        input  bcd_out, blank_out, grant, active, switch_pulse
    );

    modport slave (
        input  req, urgent, freeze, src_digits, src_blank,
        output bcd_out, blank_out, grant, active, switch_pulse
    );
endinterface

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner selection for the 8-digit display with dwell timing, freeze and urgent preemption.
module sseg_display_arbiter #(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DWELL_CYCLES = 40_000_000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    sseg_display_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
    localparam int unsigned IDX_W = $clog2(NUM_SRC);
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic {S_IDLE = 1'b0, S_SHOW = 1'b1} state_e;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_SRC - 1)) return '0;
        return i + 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_SRC-1:0] r);
        logic [IDX_W-1:0] w     = '0;
        logic             found = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!found && r[IDX_W'(k)]) begin
                found = 1'b1;
                w     = IDX_W'(k);
            end
        end
        return w;
    endfunction

    // {found, index} of the first requester at or after start, wrapping
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_SRC-1:0] r,
                                               input logic [IDX_W-1:0]   start);
        logic             found = 1'b0;
        logic [IDX_W-1:0] idx   = start;
        logic [IDX_W-1:0] win   = start;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = wrap_inc(idx);
        end
        return {found, win};
    endfunction

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    cur_q, cur_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    dwell_q, dwell_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic                active_q, active_d;
    logic                switch_q, switch_d;
    logic [31:0]         bcd_q, bcd_d;
    logic [7:0]          blank_q, blank_d;

    logic [NUM_SRC-1:0]  ureq;
    logic [IDX_W-1:0]    u_idx;
    logic [IDX_W:0]      rr_res;
    logic [IDX_W:0]      nx_res;

    assign ureq   = bus.req & bus.urgent;
    assign u_idx  = lowest(ureq);
    assign rr_res = rr_pick(bus.req, rr_ptr_q);
    // Searching from cur+1 visits cur last, so "only cur requests" resolves back to cur.
    assign nx_res = rr_pick(bus.req, wrap_inc(cur_q));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            rr_ptr_q <= '0;
            dwell_q  <= '0;
            grant_q  <= '0;
            active_q <= 1'b0;
            switch_q <= 1'b0;
            bcd_q    <= '0;
            blank_q  <= '1;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            rr_ptr_q <= rr_ptr_d;
            dwell_q  <= dwell_d;
            grant_q  <= grant_d;
            active_q <= active_d;
            switch_q <= switch_d;
            bcd_q    <= bcd_d;
            blank_q  <= blank_d;
        end
    end

    // Owner selection in priority order: preempt, owner drop, freeze, dwell expiry, count
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        rr_ptr_d = rr_ptr_q;
        dwell_d  = dwell_q;
        switch_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d  = S_SHOW;
                    cur_d    = (|ureq) ? u_idx : rr_res[IDX_W-1:0];
                    switch_d = 1'b1;
                end
            end
            S_SHOW: begin
                if ((|ureq) && !ureq[cur_q]) begin
                    cur_d    = u_idx;
                    switch_d = 1'b1;
                end else if (!bus.req[cur_q]) begin
                    if (nx_res[IDX_W]) cur_d = nx_res[IDX_W-1:0];
                    else               state_d = S_IDLE;
                    switch_d = 1'b1;
                end else if (bus.freeze) begin
                    dwell_d = dwell_q;
                end else if (dwell_q == DWELL_MAX) begin
                    // An urgent owner, or a lone requester, restarts its dwell instead of rotating.
                    if (!ureq[cur_q] && (nx_res[IDX_W-1:0] != cur_q)) begin
                        cur_d    = nx_res[IDX_W-1:0];
                        switch_d = 1'b1;
                    end else begin
                        dwell_d = '0;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (switch_d) begin
            dwell_d = '0;
            if (state_d == S_SHOW) rr_ptr_d = wrap_inc(cur_d);
        end
    end

    // Display data follows the next owner so new data lands on the same edge as the grant.
    always_comb begin
        grant_d  = '0;
        active_d = 1'b0;
        bcd_d    = '0;
        blank_d  = '1;
        if (state_d == S_SHOW) begin
            grant_d  = NUM_SRC'(1) << cur_d;
            active_d = 1'b1;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (cur_d == IDX_W'(i)) begin
                    bcd_d   = bus.src_digits[32*i +: 32];
                    blank_d = bus.src_blank[8*i +: 8];
                end
            end
        end
    end

    assign bus.bcd_out      = bcd_q;
    assign bus.blank_out    = blank_q;
    assign bus.grant        = grant_q;
    assign bus.active       = active_q;
    assign bus.switch_pulse = switch_q;

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Directed table-driven bench for sseg_display_arbiter with NUM_SRC=4, DWELL_CYCLES=8.
module tb_sseg_display_arbiter;
    localparam int unsigned NUM_SRC = 4;

    typedef struct {
        logic [3:0] req;
        logic [3:0] urg;
        logic       frz;
        int         ncyc;
        int         own;
        logic       sw;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    logic [31:0] src_d [4];
    logic [7:0]  src_b [4];
    vec_t        tbl [$];

    sseg_display_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

    sseg_display_arbiter #(.NUM_SRC(NUM_SRC), .DWELL_CYCLES(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_src();
        for (int i = 0; i < 4; i++) begin
            bus.src_digits[32*i +: 32] = src_d[i];
            bus.src_blank[8*i +: 8]    = src_b[i];
        end
    endtask

    task automatic add(input logic [3:0] req, input logic [3:0] urg, input logic frz,
                       input int ncyc, input int own, input logic sw);
        vec_t v;
        v.req = req; v.urg = urg; v.frz = frz; v.ncyc = ncyc; v.own = own; v.sw = sw;
        tbl.push_back(v);
    endtask

    task automatic chk_owner(input string tag, input int own, input logic sw);
        logic [3:0] eg;
        eg = (own >= 0) ? (4'b0001 << own) : 4'b0000;
        chk({tag, " grant"},  32'(bus.grant), 32'(eg));
        chk({tag, " switch"}, 32'(bus.switch_pulse), 32'(sw));
        chk({tag, " active"}, 32'(bus.active), 32'(own >= 0));
        if (own >= 0) begin
            chk({tag, " bcd"},   bus.bcd_out, src_d[own]);
            chk({tag, " blank"}, 32'(bus.blank_out), 32'(src_b[own]));
        end else begin
            chk({tag, " blank"}, 32'(bus.blank_out), 32'h0000_00FF);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " grant"},  32'(bus.grant), 32'h0);
        chk({tag, " active"}, 32'(bus.active), 32'h0);
        chk({tag, " switch"}, 32'(bus.switch_pulse), 32'h0);
        chk({tag, " bcd"},    bus.bcd_out, 32'h0);
        chk({tag, " blank"},  32'(bus.blank_out), 32'h0000_00FF);
    endtask

    initial begin
        logic [31:0] old_src2;
        src_d[0] = 32'h0000_0123; src_b[0] = 8'hF8;
        src_d[1] = 32'h4567_0000; src_b[1] = 8'h0F;
        src_d[2] = 32'h8989_8989; src_b[2] = 8'h00;
        src_d[3] = 32'h1357_2468; src_b[3] = 8'hAA;
        bus.req    = '0;
        bus.urgent = '0;
        bus.freeze = 1'b0;
        apply_src();

        // reset idle, rotation 0->1->3->0, preempt by urgent src2, release
        add(4'b0000, 4'b0000, 0,  3, -1, 0);
        add(4'b1011, 4'b0000, 0,  1,  0, 1);
        add(4'b1011, 4'b0000, 0,  7,  0, 0);
        add(4'b1011, 4'b0000, 0,  1,  1, 1);
        add(4'b1011, 4'b0000, 0,  7,  1, 0);
        add(4'b1011, 4'b0000, 0,  1,  3, 1);
        add(4'b1011, 4'b0000, 0,  7,  3, 0);
        add(4'b1011, 4'b0000, 0,  1,  0, 1);
        add(4'b1011, 4'b0000, 0,  3,  0, 0);
        add(4'b1111, 4'b0100, 0,  1,  2, 1);
        add(4'b1111, 4'b0100, 0, 16,  2, 0);
        add(4'b1111, 4'b0000, 0,  7,  2, 0);
        add(4'b1111, 4'b0000, 0,  1,  3, 1);
        // owner drop, then drop to idle
        add(4'b0010, 4'b0000, 0,  1,  1, 1);
        add(4'b0010, 4'b0000, 0,  2,  1, 0);
        add(4'b0000, 4'b0000, 0,  1, -1, 1);
        add(4'b0000, 4'b0000, 0,  1, -1, 0);
        // freeze mid-dwell, remaining dwell, urgent under freeze
        add(4'b0011, 4'b0000, 0,  1,  0, 1);
        add(4'b0011, 4'b0000, 0,  3,  0, 0);
        add(4'b0011, 4'b0000, 1, 20,  0, 0);
        add(4'b0011, 4'b0000, 0,  4,  0, 0);
        add(4'b0011, 4'b0000, 0,  1,  1, 1);
        add(4'b0011, 4'b0000, 1,  2,  1, 0);
        add(4'b1010, 4'b1000, 1,  1,  3, 1);
        add(4'b1010, 4'b1000, 1,  3,  3, 0);
        add(4'b0000, 4'b0000, 0,  1, -1, 1);
        // single requester across expiries, then drop+urgent together
        add(4'b0100, 4'b0000, 0,  1,  2, 1);
        add(4'b0100, 4'b0000, 0, 20,  2, 0);
        add(4'b0011, 4'b0010, 0,  1,  1, 1);

        repeat (3) @(posedge clock);
        #1;
        chk_reset_vals("reset_held");
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            bus.req    = tbl[i].req;
            bus.urgent = tbl[i].urg;
            bus.freeze = tbl[i].frz;
            for (int c = 0; c < tbl[i].ncyc; c++) begin
                step();
                chk_owner($sformatf("row%0d cyc%0d", i, c), tbl[i].own, tbl[i].sw);
            end
        end

        // urgent owner drops both req and urgent: rotate to src2
        bus.req    = 4'b0100;
        bus.urgent = 4'b0000;
        step();
        chk_owner("drop_urgent_owner", 2, 1'b1);
        step();
        step();

        // source data change reaches bcd_out one edge later
        old_src2 = src_d[2];
        src_d[2] = 32'h9876_5432;
        apply_src();
        chk("data_before_edge", bus.bcd_out, old_src2);
        step();
        chk("data_after_edge", bus.bcd_out, 32'h9876_5432);

        // async reset mid-dwell takes effect without a clock edge
        #3 reset_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        step();
        chk_reset_vals("reset_hold_edge");
        reset_n = 1'b1;
        step();
        chk_owner("after_reset_regrant", 2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
